// File: rtl/fifo_mux_param_if.sv
// fifo_mux_param_if: write/read handshake and status bundle between a FIFO and its users
interface fifo_mux_param_if #(
    parameter int bw = 8,
    parameter int depth_log2 = 4
);
    logic [bw-1:0] in_i;
    logic wr_i;
    logic rd_i;
    logic clr_err_i;
    logic [bw-1:0] out_o;
    logic full_o;
    logic empty_o;
    logic afull_o;
    logic [depth_log2:0] count_o;
    logic ovf_o;
    logic unf_o;
    modport slave (
        input in_i, wr_i, rd_i, clr_err_i,
        output out_o, full_o, empty_o, afull_o, count_o, ovf_o, unf_o
    );
    modport master (
        output in_i, wr_i, rd_i, clr_err_i,
        input out_o, full_o, empty_o, afull_o, count_o, ovf_o, unf_o
    );
endinterface

// File: rtl/fifo_mux_param.sv
// fifo_mux_param: first-word-fall-through FIFO with a DEPTH:1 read mux tree, occupancy and sticky error flags
module fifo_mux_param #(
    parameter int bw = 8,
    parameter int depth_log2 = 4,
    parameter int afull_th = 12
) (
    input logic clk,
    input logic reset,
    fifo_mux_param_if.slave bus
);
    localparam int DEPTH = 2 ** depth_log2;
    localparam logic [depth_log2:0] DEPTH_C = (depth_log2 + 1)'(DEPTH);
    localparam logic [depth_log2:0] AFULL_C = (depth_log2 + 1)'(afull_th);
    logic [bw-1:0] mem_q [DEPTH];
    logic [bw-1:0] node [1:2*DEPTH-1];
    logic [depth_log2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [depth_log2:0] count_q, count_d;
    logic ovf_q, ovf_d, unf_q, unf_d;
    logic full, empty, wa, ra;
    assign full = count_q == DEPTH_C;
    assign empty = count_q == '0;
    assign bus.full_o = full;
    assign bus.empty_o = empty;
    assign bus.afull_o = count_q >= AFULL_C;
    assign bus.count_o = count_q;
    assign bus.ovf_o = ovf_q;
    assign bus.unf_o = unf_q;
    assign bus.out_o = node[1];
    // Heap-indexed mux tree: leaves are storage entries, stage l selects on rd_ptr bit l
    for (genvar k = 0; k < DEPTH; k++) begin : g_leaf
        assign node[DEPTH+k] = mem_q[k];
    end
    for (genvar l = 0; l < depth_log2; l++) begin : g_stage
        for (genvar n = (DEPTH >> (l + 1)); n < (DEPTH >> l); n++) begin : g_node
            assign node[n] = rd_ptr_q[l] ? node[2*n+1] : node[2*n];
        end
    end
    // Accept decisions use pre-edge full/empty; set of an error flag wins over clear
    always_comb begin
        wa = bus.wr_i & ~full;
        ra = bus.rd_i & ~empty;
        wr_ptr_d = wa ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = ra ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d = (wa & ~ra) ? count_q + 1'b1 : (ra & ~wa) ? count_q - 1'b1 : count_q;
        ovf_d = (ovf_q & ~bus.clr_err_i) | (bus.wr_i & full);
        unf_d = (unf_q & ~bus.clr_err_i) | (bus.rd_i & empty);
    end
    // Control state with synchronous active-low reset taking priority
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end
    // Storage array is never reset; only accepted writes outside reset update it
    always_ff @(posedge clk) begin
        if (reset && wa) mem_q[wr_ptr_q] <= bus.in_i;
    end
endmodule

// File: tb/tb_fifo_mux_param.sv
// tb_fifo_mux_param: scoreboard bench for fifo_mux_param at default parameters
module tb_fifo_mux_param;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] sb[$];
    logic m_ovf = 1'b0;
    logic m_unf = 1'b0;
    logic m_valid = 1'b0;
    fifo_mux_param_if #(.bw(8), .depth_log2(4)) bus ();
    fifo_mux_param #(.bw(8), .depth_log2(4), .afull_th(12)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    // One cycle: drive inputs, compare pre-edge outputs with the model, advance the model, clock
    task automatic step(input logic rn, input logic w, input logic r, input logic [7:0] d, input logic c);
        int sz;
        reset = rn;
        bus.wr_i = w;
        bus.rd_i = r;
        bus.in_i = d;
        bus.clr_err_i = c;
        sz = sb.size();
        if (m_valid) begin
            check("count", 32'(bus.count_o), sz);
            check("full", 32'(bus.full_o), 32'(sz == 16));
            check("empty", 32'(bus.empty_o), 32'(sz == 0));
            check("afull", 32'(bus.afull_o), 32'(sz >= 12));
            check("ovf", 32'(bus.ovf_o), 32'(m_ovf));
            check("unf", 32'(bus.unf_o), 32'(m_unf));
            if (r && sz != 0) check("out", 32'(bus.out_o), 32'(sb[0]));
        end
        if (!rn) begin
            sb.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_valid = 1'b1;
        end else begin
            m_ovf = (m_ovf && !c) || (w && sz == 16);
            m_unf = (m_unf && !c) || (r && sz == 0);
            if (r && sz != 0) void'(sb.pop_front());
            if (w && sz != 16) sb.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask
    initial begin
        bus.wr_i = 1'b0;
        bus.rd_i = 1'b0;
        bus.in_i = '0;
        bus.clr_err_i = 1'b0;
        @(posedge clk);
        #1;
        repeat (2) step(1'b0, 1'b1, 1'b0, 8'hAA, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 1; i <= 16; i++) step(1'b1, 1'b1, 1'b0, 8'(i), 1'b0);
        repeat (16) step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h30 + i), 1'b0);
        repeat (10) step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
        repeat (12) step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
        step(1'b1, 1'b1, 1'b1, 8'hEE, 1'b0);
        repeat (15) step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b1, 1'b1, 1'b1, 8'h5A, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1, 8'(8'h20 + i), 1'b0);
        repeat (5) step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 300; i++)
            step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 15) == 0));
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
